inst_fetch: RTL

Instruction fetch and field-decode stage of the RV32I pipeline. Holds the program counter and issues one word request at a time to instruction memory. It slices each returned instruction into the type, function, immediate and register fields consumed by the IF/ID register. Hazard-unit stalls and execute-stage branch/jump redirects are handled here, using a one-entry skid buffer so that no fetched word is lost.

---
 rtl/inst_fetch.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// inst_fetch : RV32I fetch + field decode with one-entry skid buffer  (rev 1.0)
// ============================================================================
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] pc,
  output logic [2:0]  inst_type,
  output logic [2:0]  funct3,
  output logic [5:0]  funct7,
  output logic [31:0] imm,
  output logic [4:0]  rs,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [2:0] c_T_R   = 3'd0;
  localparam logic [2:0] c_T_I   = 3'd1;
  localparam logic [2:0] c_T_S   = 3'd2;
  localparam logic [2:0] c_T_B   = 3'd3;
  localparam logic [2:0] c_T_U   = 3'd4;
  localparam logic [2:0] c_T_J   = 3'd5;
  localparam logic [2:0] c_T_BAD = 3'd7;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_skid_inst;
  logic [31:0] r_skid_pc;

  logic [31:0] w_inst;
  logic [2:0]  w_type;
  logic [31:0] w_imm;
  logic        w_take;
  logic        w_unload;
  logic        w_bubble;
  logic        w_park;

  assign imem_req  = (r_state == ST_REQ);
  assign imem_addr = r_fetch_pc;

  // In HOLD the decoder looks at the parked word; otherwise at live memory data.
  assign w_inst   = (r_state == ST_HOLD) ? r_skid_inst : imem_rdata;
  assign w_take   = (r_state == ST_REQ)  &&  imem_ack && !stall;
  assign w_park   = (r_state == ST_REQ)  &&  imem_ack &&  stall;
  assign w_bubble = (r_state == ST_REQ)  && !imem_ack && !stall;
  assign w_unload = (r_state == ST_HOLD) && !stall;

  always_comb begin
    w_type = c_T_BAD;
    w_imm  = 32'h0;
    case (w_inst[6:0])
      7'b0110011: w_type = c_T_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        w_type = c_T_I;
        w_imm  = {{20{w_inst[31]}}, w_inst[31:20]};
      end
      7'b0100011: begin
        w_type = c_T_S;
        w_imm  = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      end
      7'b1100011: begin
        w_type = c_T_B;
        w_imm  = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_type = c_T_U;
        w_imm  = {w_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        w_type = c_T_J;
        w_imm  = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
      end
      default: begin
        w_type = c_T_BAD;
        w_imm  = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_REQ;
      r_fetch_pc  <= RESET_PC;
      r_skid_inst <= 32'h0;
      r_skid_pc   <= 32'h0;
      valid       <= 1'b0;
      pc          <= 32'h0;
      inst_type   <= c_T_BAD;
      funct3      <= 3'h0;
      funct7      <= 6'h0;
      imm         <= 32'h0;
      rs          <= 5'h0;
      rs2         <= 5'h0;
      rd          <= 5'h0;
    end else if (redirect) begin
      // Any ack arriving this cycle belongs to the abandoned path and is dropped.
      r_state    <= ST_REQ;
      r_fetch_pc <= redirect_pc;
      valid      <= 1'b0;
      inst_type  <= c_T_BAD;
    end else begin
      if (w_take || w_unload) begin
        valid     <= 1'b1;
        pc        <= w_unload ? r_skid_pc : r_fetch_pc;
        inst_type <= w_type;
        funct3    <= w_inst[14:12];
        funct7    <= w_inst[30:25];
        imm       <= w_imm;
        rs        <= w_inst[19:15];
        rs2       <= w_inst[24:20];
        rd        <= w_inst[11:7];
      end else if (w_bubble) begin
        valid     <= 1'b0;
        inst_type <= c_T_BAD;
      end
      if (w_take || w_park) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_park) begin
        r_skid_inst <= imem_rdata;
        r_skid_pc   <= r_fetch_pc;
        r_state     <= ST_HOLD;
      end
      if (w_unload) begin
        r_state <= ST_REQ;
      end
    end
  end

endmodule
`default_nettype wire
